// File: rtl/usb_bi_pkg.sv
// Shared definitions for the USB core Wishbone bus interface:
// address region codes, FSM state type and the one-hot select bundle.
package usb_bi_pkg;

    // address[7:4] values that select each sub-block
    localparam logic [3:0] HOST_CTRL_REGION  = 4'h0;
    localparam logic [3:0] FIFO_REGION       = 4'h2;
    localparam logic [3:0] SLAVE_CTRL_REGION = 4'h4;
    localparam logic [3:0] HSMUX_REGION      = 4'h6;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        ACK    = 2'd2
    } bi_state_t;

    // One-hot block select; all zero for an unmapped address
    typedef struct packed {
        logic hsmux;
        logic slave_ctrl;
        logic fifo;
        logic host_ctrl;
    } bi_sel_t;

    // Map the upper address nibble onto the block selects
    function automatic bi_sel_t decode_region(input logic [3:0] region);
        bi_sel_t sel;
        sel = '0;
        case (region)
            HOST_CTRL_REGION:  sel.host_ctrl  = 1'b1;
            FIFO_REGION:       sel.fifo       = 1'b1;
            SLAVE_CTRL_REGION: sel.slave_ctrl = 1'b1;
            HSMUX_REGION:      sel.hsmux      = 1'b1;
            default:           sel = '0;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/bus_read_mux.sv
// Read-data return path: OR-combines the selected sub-block's read data
// and registers it onto the Wishbone data output at the end of ACCESS.
module bus_read_mux
    import usb_bi_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       load_en,
    input  bi_sel_t    sel,
    input  logic       write_en,
    input  logic [7:0] host_ctrl_rd_data,
    input  logic [7:0] fifo_rd_data,
    input  logic [7:0] slave_ctrl_rd_data,
    input  logic [7:0] hsmux_rd_data,
    output logic [7:0] data_out
);

    logic [7:0] data_out_q;
    logic [7:0] data_out_d;

    // Select read data; writes and unmapped addresses return zero
    always_comb begin
        data_out_d = data_out_q;
        if (load_en) begin
            if (write_en) begin
                data_out_d = '0;
            end else begin
                data_out_d = ({8{sel.host_ctrl}}  & host_ctrl_rd_data)
                           | ({8{sel.fifo}}       & fifo_rd_data)
                           | ({8{sel.slave_ctrl}} & slave_ctrl_rd_data)
                           | ({8{sel.hsmux}}      & hsmux_rd_data);
            end
        end
    end

    // Output data register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_out_q <= '0;
        end else begin
            data_out_q <= data_out_d;
        end
    end

    assign data_out = data_out_q;

endmodule

// File: rtl/wishbone_bus_bi.sv
// Wishbone classic slave front end: decodes the address into block selects,
// re-times each bus cycle into a single-cycle registered strobe bundle and
// returns registered read data with a one-cycle ack.
module wishbone_bus_bi
    import usb_bi_pkg::*;
(
    input  logic       busClk,
    input  logic       rst,
    input  logic [7:0] address,
    input  logic [7:0] dataIn,
    input  logic       writeEn,
    input  logic       strobe_i,
    input  logic       cyc_i,
    output logic       ack_o,
    output logic [7:0] dataOut,
    output logic [3:0] regAddr,
    output logic [7:0] regDataOut,
    output logic       regWriteEn,
    output logic       strobeOut,
    output logic       hostCtrlSel,
    output logic       fifoSel,
    output logic       slaveCtrlSel,
    output logic       hostSlaveMuxSel,
    input  logic [7:0] hostCtrlRdData,
    input  logic [7:0] fifoRdData,
    input  logic [7:0] slaveCtrlRdData,
    input  logic [7:0] hostSlaveMuxRdData
);

    bi_state_t  state_q, state_d;
    logic [3:0] reg_addr_q, reg_addr_d;
    logic [7:0] reg_data_q, reg_data_d;
    logic       reg_we_q, reg_we_d;
    bi_sel_t    sel_q, sel_d;
    logic       strobe_q, strobe_d;
    logic       ack_q, ack_d;
    logic       load_rd;

    // Next-state, capture and output decode
    always_comb begin
        state_d    = state_q;
        reg_addr_d = reg_addr_q;
        reg_data_d = reg_data_q;
        reg_we_d   = reg_we_q;
        sel_d      = sel_q;
        strobe_d   = 1'b0;
        ack_d      = 1'b0;
        load_rd    = 1'b0;
        case (state_q)
            IDLE: begin
                if (cyc_i && strobe_i) begin
                    reg_addr_d = address[3:0];
                    reg_data_d = dataIn;
                    reg_we_d   = writeEn;
                    sel_d      = decode_region(address[7:4]);
                    strobe_d   = |decode_region(address[7:4]);
                    state_d    = ACCESS;
                end
            end
            ACCESS: begin
                load_rd = 1'b1;
                ack_d   = 1'b1;
                state_d = ACK;
            end
            ACK: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and registered bus bundle
    always_ff @(posedge busClk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            reg_addr_q <= '0;
            reg_data_q <= '0;
            reg_we_q   <= 1'b0;
            sel_q      <= '0;
            strobe_q   <= 1'b0;
            ack_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            reg_addr_q <= reg_addr_d;
            reg_data_q <= reg_data_d;
            reg_we_q   <= reg_we_d;
            sel_q      <= sel_d;
            strobe_q   <= strobe_d;
            ack_q      <= ack_d;
        end
    end

    bus_read_mux u_read_mux (
        .clk                (busClk),
        .rst                (rst),
        .load_en            (load_rd),
        .sel                (sel_q),
        .write_en           (reg_we_q),
        .host_ctrl_rd_data  (hostCtrlRdData),
        .fifo_rd_data       (fifoRdData),
        .slave_ctrl_rd_data (slaveCtrlRdData),
        .hsmux_rd_data      (hostSlaveMuxRdData),
        .data_out           (dataOut)
    );

    assign ack_o           = ack_q;
    assign strobeOut       = strobe_q;
    assign regAddr         = reg_addr_q;
    assign regDataOut      = reg_data_q;
    assign regWriteEn      = reg_we_q;
    assign hostCtrlSel     = sel_q.host_ctrl;
    assign fifoSel         = sel_q.fifo;
    assign slaveCtrlSel    = sel_q.slave_ctrl;
    assign hostSlaveMuxSel = sel_q.hsmux;

endmodule
